// File: rtl/free_reg_arbiter_if.sv
// Request/grant bundle between the requesters and the shared-register arbiter,
// plus the enable/data pair that the arbiter drives into the shared register.
interface free_reg_arbiter_if #(
   parameter int N = 4,
   parameter int M = 4
) ();
   localparam int OW = $clog2(M);

   logic [M-1:0]   req;
   logic [M*N-1:0] data;
   logic [M-1:0]   gnt;
   logic           ack;
   logic [OW-1:0]  owner;
   logic           busy;
   logic           reg_en;
   logic [N-1:0]   reg_d;

   modport master (output req, data, input gnt, ack, owner, busy, reg_en, reg_d);
   modport slave  (input req, data, output gnt, ack, owner, busy, reg_en, reg_d);
endinterface

// File: rtl/free_reg_arbiter.sv
// Round-robin arbiter that loads one requester's data into a shared register,
// then holds the grant for HOLD dwell cycles before arbitrating again.
module free_reg_arbiter #(
   parameter int N    = 4,
   parameter int M    = 4,
   parameter int HOLD = 3
) (
   input  logic              clk,
   input  logic              reset,
   free_reg_arbiter_if.slave bus
);
   localparam int OW = $clog2(M);
   localparam int CW = $clog2(HOLD + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [OW-1:0] PTR_LAST = OW'(M - 1);
   localparam logic [OW-1:0] PTR_ONE  = OW'(1);
   localparam logic [M-1:0]  GNT_ONE  = {{(M-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   state_t        state_r, state_nx_s;
   logic [OW-1:0] ptr_r, ptr_nx_s;
   logic [OW-1:0] owner_r, owner_nx_s;
   logic [OW-1:0] win_s, idx_s;
   logic [CW-1:0] cnt_r, cnt_nx_s;
   logic [M-1:0]  gnt_r, gnt_nx_s;
   logic [N-1:0]  reg_d_r, reg_d_nx_s;
   logic          ack_r, ack_nx_s;
   logic          reg_en_r, reg_en_nx_s;
   logic          busy_r, busy_nx_s;
   logic          found_s;

   // Round-robin pick: scanning downward lets the candidate closest to ptr win last.
   always_comb begin
      found_s = |bus.req;
      win_s   = ptr_r;
      idx_s   = ptr_r;
      for (int i = M - 1; i >= 0; i--) begin
         idx_s = OW'((int'(ptr_r) + i) % M);
         win_s = bus.req[idx_s] ? idx_s : win_s;
      end
   end

   // Next-state and next-output logic; every output register is fed from here.
   always_comb begin
      state_nx_s  = state_r;
      ptr_nx_s    = ptr_r;
      cnt_nx_s    = cnt_r;
      gnt_nx_s    = gnt_r;
      owner_nx_s  = owner_r;
      reg_d_nx_s  = reg_d_r;
      ack_nx_s    = 1'b0;
      reg_en_nx_s = 1'b0;
      busy_nx_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (found_s) begin
               state_nx_s  = ST_LOAD;
               reg_d_nx_s  = bus.data[int'(win_s) * N +: N];
               owner_nx_s  = win_s;
               gnt_nx_s    = GNT_ONE << win_s;
               ptr_nx_s    = (win_s == PTR_LAST) ? '0 : (win_s + PTR_ONE);
               cnt_nx_s    = CNT_LOAD;
               ack_nx_s    = 1'b1;
               reg_en_nx_s = 1'b1;
               busy_nx_s   = 1'b1;
            end else begin
               gnt_nx_s = '0;
            end
         end
         ST_LOAD: begin
            state_nx_s = ST_HOLD;
            busy_nx_s  = 1'b1;
         end
         ST_HOLD: begin
            if (cnt_r == '0) begin
               state_nx_s = ST_IDLE;
               gnt_nx_s   = '0;
            end else begin
               cnt_nx_s  = cnt_r - CNT_ONE;
               busy_nx_s = 1'b1;
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
            gnt_nx_s   = '0;
         end
      endcase
   end

   // State and output registers; reset drops any load in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r  <= ST_IDLE;
         ptr_r    <= '0;
         cnt_r    <= '0;
         gnt_r    <= '0;
         owner_r  <= '0;
         reg_d_r  <= '0;
         ack_r    <= 1'b0;
         reg_en_r <= 1'b0;
         busy_r   <= 1'b0;
      end else begin
         state_r  <= state_nx_s;
         ptr_r    <= ptr_nx_s;
         cnt_r    <= cnt_nx_s;
         gnt_r    <= gnt_nx_s;
         owner_r  <= owner_nx_s;
         reg_d_r  <= reg_d_nx_s;
         ack_r    <= ack_nx_s;
         reg_en_r <= reg_en_nx_s;
         busy_r   <= busy_nx_s;
      end
   end

   assign bus.gnt    = gnt_r;
   assign bus.ack    = ack_r;
   assign bus.owner  = owner_r;
   assign bus.busy   = busy_r;
   assign bus.reg_en = reg_en_r;
   assign bus.reg_d  = reg_d_r;

endmodule

// File: tb/tb_free_reg_arbiter.sv
// Scoreboard bench for free_reg_arbiter: a 4x4/HOLD=3 instance and a 2x4/HOLD=1
// instance, each feeding a model of the shared register.
module tb_free_reg_arbiter;
   logic clk;
   logic reset;

   free_reg_arbiter_if #(.N(4), .M(4)) b1 ();
   free_reg_arbiter_if #(.N(4), .M(2)) b2 ();

   free_reg_arbiter #(.N(4), .M(4), .HOLD(3)) u_dut1 (.clk(clk), .reset(reset), .bus(b1));
   free_reg_arbiter #(.N(4), .M(2), .HOLD(1)) u_dut2 (.clk(clk), .reset(reset), .bus(b2));

   typedef struct {
      logic [1:0] owner;
      logic [3:0] data;
      int         spacing;
   } exp_t;

   exp_t q1[$];
   exp_t q2[$];
   int   n_chk  = 0;
   int   n_pass = 0;
   logic [3:0] s_out1;
   logic [3:0] s_out2;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Shared free-running registers fed only by the arbiters.
   always_ff @(posedge clk) begin
      if (b1.reg_en) s_out1 <= b1.reg_d;
      if (b2.reg_en) s_out2 <= b2.reg_d;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   task automatic wait_ack(input bit which);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(posedge clk);
         #1;
         seen = which ? b2.ack : b1.ack;
      end
      chk("ack_timeout", {31'd0, seen}, 32'd1);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 reset = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Monitor for the 4-requester instance.
   initial begin : mon1
      exp_t e;
      int   cyc, last;
      bit   pend;
      logic [3:0] sexp;
      cyc = 0; last = 0; pend = 1'b0; sexp = 4'h0;
      forever begin
         @(negedge clk);
         cyc++;
         if (pend) begin
            chk("s_out1", s_out1, sexp);
            pend = 1'b0;
         end
         chk("reg_en1_vs_ack", b1.reg_en, b1.ack);
         if (b1.ack) begin
            if (q1.size() == 0) begin
               chk("unexpected_ack1", b1.ack, 1'b0);
            end else begin
               e = q1.pop_front();
               chk("owner1", b1.owner, e.owner);
               chk("gnt1", b1.gnt, 4'b0001 << e.owner);
               chk("reg_d1", b1.reg_d, e.data);
               chk("busy1_in_load", b1.busy, 1'b1);
               if (e.spacing != 0) chk("ack_spacing1", cyc - last, e.spacing);
               sexp = e.data;
               pend = 1'b1;
            end
            last = cyc;
         end
      end
   end

   // Monitor for the 2-requester instance.
   initial begin : mon2
      exp_t e;
      int   cyc, last;
      bit   pend;
      logic [3:0] sexp;
      cyc = 0; last = 0; pend = 1'b0; sexp = 4'h0;
      forever begin
         @(negedge clk);
         cyc++;
         if (pend) begin
            chk("s_out2", s_out2, sexp);
            pend = 1'b0;
         end
         chk("reg_en2_vs_ack", b2.reg_en, b2.ack);
         if (b2.ack) begin
            if (q2.size() == 0) begin
               chk("unexpected_ack2", b2.ack, 1'b0);
            end else begin
               e = q2.pop_front();
               chk("owner2", b2.owner, e.owner[0]);
               chk("gnt2", b2.gnt, 2'b01 << e.owner[0]);
               chk("reg_d2", b2.reg_d, e.data);
               if (e.spacing != 0) chk("ack_spacing2", cyc - last, e.spacing);
               sexp = e.data;
               pend = 1'b1;
            end
            last = cyc;
         end
      end
   end

   initial begin : stim
      int busy_n;
      reset = 1'b0;
      b1.req = 4'b0000; b1.data = 16'h0000;
      b2.req = 2'b00;   b2.data = 8'h00;

      // Reset state
      repeat (2) begin
         @(negedge clk);
         chk("rst_gnt", b1.gnt, 4'b0000);
         chk("rst_ack", b1.ack, 1'b0);
         chk("rst_reg_en", b1.reg_en, 1'b0);
         chk("rst_reg_d", b1.reg_d, 4'h0);
         chk("rst_owner", b1.owner, 2'd0);
         chk("rst_busy", b1.busy, 1'b0);
         chk("rst_busy2", b2.busy, 1'b0);
      end
      @(posedge clk);
      #1 reset = 1'b1;
      idle(3);
      chk("idle_busy", b1.busy, 1'b0);

      // Single requester 2
      @(posedge clk); #1;
      q1.push_back('{2'd2, 4'hA, 0});
      b1.data = 16'h0A00; b1.req = 4'b0100;
      wait_ack(1'b0);
      b1.req = 4'b0000;
      busy_n = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (b1.busy) busy_n++;
      end
      chk("busy_cycles1", busy_n, 4);
      chk("owner_kept", b1.owner, 2'd2);
      chk("gnt_idle", b1.gnt, 4'b0000);

      // All four requesting: 0,1,2,3,0 every 5 cycles
      do_reset();
      @(posedge clk); #1;
      q1.push_back('{2'd0, 4'h1, 0});
      q1.push_back('{2'd1, 4'h2, 5});
      q1.push_back('{2'd2, 4'h3, 5});
      q1.push_back('{2'd3, 4'h4, 5});
      q1.push_back('{2'd0, 4'h1, 5});
      b1.data = 16'h4321; b1.req = 4'b1111;
      for (int k = 0; k < 5; k++) wait_ack(1'b0);
      b1.req = 4'b0000;
      idle(8);

      // 3 wins first, then 1001 alternates 0,3,0
      do_reset();
      @(posedge clk); #1;
      q1.push_back('{2'd3, 4'hC, 0});
      q1.push_back('{2'd0, 4'h5, 5});
      q1.push_back('{2'd3, 4'hC, 5});
      q1.push_back('{2'd0, 4'h5, 5});
      b1.data = 16'hC005; b1.req = 4'b1000;
      wait_ack(1'b0);
      b1.req = 4'b1001;
      for (int k = 0; k < 3; k++) wait_ack(1'b0);
      b1.req = 4'b0000;
      idle(8);

      // Drop req and change data mid-dwell
      @(posedge clk); #1;
      q1.push_back('{2'd1, 4'h7, 0});
      b1.data = 16'h0070; b1.req = 4'b0010;
      wait_ack(1'b0);
      repeat (2) @(posedge clk);
      #1;
      b1.req = 4'b0000; b1.data = 16'h00F0;
      @(negedge clk);
      chk("hold_reg_d", b1.reg_d, 4'h7);
      chk("hold_gnt", b1.gnt, 4'b0010);
      chk("hold_busy", b1.busy, 1'b1);
      @(negedge clk);
      chk("hold_reg_d_last", b1.reg_d, 4'h7);
      chk("hold_gnt_last", b1.gnt, 4'b0010);
      idle(6);
      chk("after_hold_gnt", b1.gnt, 4'b0000);
      chk("after_hold_reg_d", b1.reg_d, 4'h7);
      chk("after_hold_busy", b1.busy, 1'b0);

      // Reset during LOAD
      @(posedge clk); #1;
      b1.data = 16'h0B00; b1.req = 4'b0100;
      wait_ack(1'b0);
      reset = 1'b0;
      #1;
      chk("rstload_ack", b1.ack, 1'b0);
      chk("rstload_reg_en", b1.reg_en, 1'b0);
      chk("rstload_gnt", b1.gnt, 4'b0000);
      chk("rstload_busy", b1.busy, 1'b0);
      chk("rstload_reg_d", b1.reg_d, 4'h0);
      b1.req = 4'b0000;
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      q1.push_back('{2'd2, 4'hD, 0});
      b1.data = 16'hED00; b1.req = 4'b1100;
      wait_ack(1'b0);
      b1.req = 4'b0000;
      idle(6);

      // Reset mid-dwell
      @(posedge clk); #1;
      q1.push_back('{2'd1, 4'h6, 0});
      b1.data = 16'h0060; b1.req = 4'b0010;
      wait_ack(1'b0);
      b1.req = 4'b0000;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      chk("rsthold_gnt", b1.gnt, 4'b0000);
      chk("rsthold_busy", b1.busy, 1'b0);
      chk("rsthold_reg_d", b1.reg_d, 4'h0);
      chk("rsthold_owner", b1.owner, 2'd0);
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      q1.push_back('{2'd0, 4'h9, 0});
      b1.data = 16'h3009; b1.req = 4'b1001;
      wait_ack(1'b0);
      b1.req = 4'b0000;
      idle(6);

      // Two requesters, one dwell cycle
      do_reset();
      @(posedge clk); #1;
      q2.push_back('{2'd1, 4'hA, 0});
      b2.data = 8'hA0; b2.req = 2'b10;
      wait_ack(1'b1);
      b2.req = 2'b00;
      busy_n = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (b2.busy) busy_n++;
      end
      chk("busy_cycles2", busy_n, 2);
      do_reset();
      @(posedge clk); #1;
      q2.push_back('{2'd0, 4'h1, 0});
      q2.push_back('{2'd1, 4'h2, 3});
      q2.push_back('{2'd0, 4'h1, 3});
      b2.data = 8'h21; b2.req = 2'b11;
      for (int k = 0; k < 3; k++) wait_ack(1'b1);
      b2.req = 2'b00;
      idle(6);

      chk("q1_drained", q1.size(), 0);
      chk("q2_drained", q2.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
